// File: rtl/axis_flit_deserializer_pkg.sv
// Shared width helpers for the flit deserializer slice.
package axis_flit_deserializer_pkg;

   // Index width that stays at least one bit wide for single-entry ranges.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width able to hold the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/axis_flit_deserializer_chk.sv
// Protocol checks for the deserializer: buffer overflow, credit pulses, AXIS hold rules.
module axis_flit_deserializer_chk #(
   parameter int TDATA_WIDTH = 512,
   parameter int DEST_WIDTH  = 6
) (
   input logic                   clk,
   input logic                   rst_n,
   input logic                   push_i,
   input logic                   full_i,
   input logic                   pop_i,
   input logic                   overflow_i,
   input logic                   credit_i,
   input logic                   tvalid_i,
   input logic                   tready_i,
   input logic [TDATA_WIDTH-1:0] tdata_i,
   input logic                   tlast_i,
   input logic [DEST_WIDTH-1:0]  tdest_i
);
   a_full_push_flagged: assert property (@(posedge clk) disable iff (!rst_n)
      (push_i && full_i && !pop_i) |=> overflow_i);

   a_credit_one_per_pop: assert property (@(posedge clk) disable iff (!rst_n)
      credit_i |-> $past(pop_i));

   a_axis_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (tvalid_i && !tready_i) |=>
         (tvalid_i && $stable(tdata_i) && $stable(tlast_i) && $stable(tdest_i)));

endmodule

// File: rtl/axis_flit_deserializer_fifo.sv
// Flit buffer with a registered credit pulse per pop; the upstream credit pool equals DEPTH.
module axis_flit_deserializer_fifo
   import axis_flit_deserializer_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 4,
   parameter int FORCE_MLAB = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             overflow_o,
   output logic             credit_o
);
   localparam int PTR_W = idx_width(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q, credit_q;
   logic             do_pop, do_push;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
   endfunction

   assign empty_o = (count_q == CNT_W'(0));
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a push into a full buffer is still taken.
   assign do_push = push_i && (!full_o || do_pop);

   // Pointers, occupancy, sticky overflow and credit pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         credit_q   <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (push_i && !do_push) overflow_q <= 1'b1;
         credit_q <= do_pop;
      end
   end

   if (FORCE_MLAB != 0) begin : g_mlab
      (* ramstyle = "MLAB, no_rw_check" *) logic [WIDTH-1:0] mem_q [DEPTH];
      // Storage write port.
      always_ff @(posedge clk) begin
         if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
      end
      assign rd_data_o = mem_q[rd_ptr_q];
   end else begin : g_reg
      logic [WIDTH-1:0] mem_q [DEPTH];
      // Storage write port.
      always_ff @(posedge clk) begin
         if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
      end
      assign rd_data_o = mem_q[rd_ptr_q];
   end

   assign overflow_o = overflow_q;
   assign credit_o   = credit_q;

endmodule

// File: rtl/axis_flit_deserializer.sv
// NoC ejection endpoint: buffers credit-controlled flits and reassembles LSB-first flits
// into AXI-Stream beats held in a single output register.
module axis_flit_deserializer
   import axis_flit_deserializer_pkg::*;
#(
   parameter int TDATA_WIDTH          = 512,
   parameter int DEST_WIDTH           = 6,
   parameter int SERIALIZATION_FACTOR = 4,
   parameter int FLIT_BUFFER_DEPTH    = 4,
   parameter int FORCE_MLAB           = 0,
   localparam int FLIT_WIDTH          = TDATA_WIDTH / SERIALIZATION_FACTOR
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [FLIT_WIDTH-1:0]  data_in,
   input  logic [DEST_WIDTH-1:0]  dest_in,
   input  logic                   is_tail_in,
   input  logic                   send_in,
   output logic                   credit_out,
   output logic                   axis_tvalid,
   input  logic                   axis_tready,
   output logic [TDATA_WIDTH-1:0] axis_tdata,
   output logic                   axis_tlast,
   output logic [DEST_WIDTH-1:0]  axis_tdest,
   output logic                   overflow_err,
   output logic                   framing_err
);
   localparam int SF    = SERIALIZATION_FACTOR;
   localparam int IDX_W = idx_width(SF);

   typedef struct packed {
      logic [FLIT_WIDTH-1:0] data;
      logic [DEST_WIDTH-1:0] dest;
      logic                  is_tail;
   } flit_t;

   flit_t wr_flit, head;
   logic  empty, full, pop, last_idx, complete;
   logic [TDATA_WIDTH-1:0] beat;

   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [TDATA_WIDTH-1:0] acc_q, acc_d, tdata_q, tdata_d;
   logic [DEST_WIDTH-1:0]  dest_q, dest_d, tdest_q, tdest_d;
   logic                   tvalid_q, tvalid_d, tlast_q, tlast_d, framing_q, framing_d;

   assign wr_flit = '{data: data_in, dest: dest_in, is_tail: is_tail_in};

   axis_flit_deserializer_fifo #(
      .WIDTH      ($bits(flit_t)),
      .DEPTH      (FLIT_BUFFER_DEPTH),
      .FORCE_MLAB (FORCE_MLAB)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (send_in),
      .wr_data_i  (wr_flit),
      .pop_i      (pop),
      .rd_data_o  (head),
      .empty_o    (empty),
      .full_o     (full),
      .overflow_o (overflow_err),
      .credit_o   (credit_out)
   );

   // Assembler: merge head flit into the partial beat and load the output register on completion.
   always_comb begin
      beat     = acc_q;
      beat[idx_q*FLIT_WIDTH +: FLIT_WIDTH] = head.data;
      last_idx = (idx_q == IDX_W'(SF - 1));
      complete = last_idx || head.is_tail;
      // Only a completing flit needs the output register free (or draining this cycle).
      pop      = !empty && (!complete || !tvalid_q || axis_tready);

      idx_d     = idx_q;
      acc_d     = acc_q;
      dest_d    = dest_q;
      framing_d = framing_q;
      tvalid_d  = (tvalid_q && axis_tready) ? 1'b0 : tvalid_q;
      tdata_d   = tdata_q;
      tlast_d   = tlast_q;
      tdest_d   = tdest_q;

      if (pop) begin
         if (idx_q == IDX_W'(0)) begin
            dest_d = head.dest;
         end else if (head.dest != dest_q) begin
            framing_d = 1'b1;
         end else begin
            dest_d = dest_q;
         end
         if (complete) begin
            if (!last_idx) framing_d = 1'b1;
            tvalid_d = 1'b1;
            tdata_d  = beat;
            tlast_d  = head.is_tail;
            tdest_d  = (idx_q == IDX_W'(0)) ? head.dest : dest_q;
            acc_d    = '0;
            idx_d    = '0;
         end else begin
            acc_d = beat;
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         idx_d = idx_q;
      end
   end

   // Assembler and output register state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         acc_q     <= '0;
         dest_q    <= '0;
         framing_q <= 1'b0;
         tvalid_q  <= 1'b0;
         tdata_q   <= '0;
         tlast_q   <= 1'b0;
         tdest_q   <= '0;
      end else begin
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         dest_q    <= dest_d;
         framing_q <= framing_d;
         tvalid_q  <= tvalid_d;
         tdata_q   <= tdata_d;
         tlast_q   <= tlast_d;
         tdest_q   <= tdest_d;
      end
   end

   assign axis_tvalid = tvalid_q;
   assign axis_tdata  = tdata_q;
   assign axis_tlast  = tlast_q;
   assign axis_tdest  = tdest_q;
   assign framing_err = framing_q;

   axis_flit_deserializer_chk #(
      .TDATA_WIDTH (TDATA_WIDTH),
      .DEST_WIDTH  (DEST_WIDTH)
   ) u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (send_in),
      .full_i     (full),
      .pop_i      (pop),
      .overflow_i (overflow_err),
      .credit_i   (credit_out),
      .tvalid_i   (axis_tvalid),
      .tready_i   (axis_tready),
      .tdata_i    (axis_tdata),
      .tlast_i    (axis_tlast),
      .tdest_i    (axis_tdest)
   );

endmodule

// File: tb/tb_axis_flit_deserializer.sv
// Directed self-checking bench for axis_flit_deserializer (default parameters: 4 x 128-bit flits).
module tb_axis_flit_deserializer;
   localparam int TW    = 512;
   localparam int DW    = 6;
   localparam int FW    = 128;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [FW-1:0] data_in = '0;
   logic [DW-1:0] dest_in = '0;
   logic          is_tail_in = 1'b0;
   logic          send_in = 1'b0;
   logic          credit_out;
   logic          axis_tvalid;
   logic          axis_tready = 1'b0;
   logic [TW-1:0] axis_tdata;
   logic          axis_tlast;
   logic [DW-1:0] axis_tdest;
   logic          overflow_err;
   logic          framing_err;

   int errors = 0;
   int checks = 0;
   int sent = 0;
   int credits_ret = 0;
   int timeouts = 0;
   int cyc = 0;
   logic [TW-1:0] bq[$];
   logic          lq[$];
   logic [DW-1:0] dq[$];
   int            hq[$];

   axis_flit_deserializer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .dest_in      (dest_in),
      .is_tail_in   (is_tail_in),
      .send_in      (send_in),
      .credit_out   (credit_out),
      .axis_tvalid  (axis_tvalid),
      .axis_tready  (axis_tready),
      .axis_tdata   (axis_tdata),
      .axis_tlast   (axis_tlast),
      .axis_tdest   (axis_tdest),
      .overflow_err (overflow_err),
      .framing_err  (framing_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Upstream credit counter, cleared by the same reset as the DUT.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) credits_ret <= 0;
      else if (credit_out) credits_ret <= credits_ret + 1;
   end

   // Beat monitor: records every AXIS handshake.
   always @(negedge clk) begin
      if (rst_n && axis_tvalid && axis_tready) begin
         bq.push_back(axis_tdata);
         lq.push_back(axis_tlast);
         dq.push_back(axis_tdest);
         hq.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_flit(input int d, input int dst, input bit tail, input bit honour);
      int w = 0;
      while (honour && (sent - credits_ret) >= DEPTH && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) timeouts++;
      data_in    = FW'(d);
      dest_in    = DW'(dst);
      is_tail_in = tail;
      send_in    = 1'b1;
      tick();
      send_in    = 1'b0;
      is_tail_in = 1'b0;
      sent++;
   endtask

   task automatic wait_beats(input int target, input int budget);
      int w = 0;
      while (bq.size() < target && w < budget) begin
         tick();
         w++;
      end
   endtask

   function automatic logic [TW-1:0] mk_beat(input int base, input int n);
      logic [TW-1:0] e = '0;
      for (int k = 0; k < n; k++) e[k*FW +: FW] = FW'(base + k);
      return e;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", axis_tvalid); end
      checks++; if (axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", axis_tdata); end
      checks++; if (axis_tlast !== 1'b0 || axis_tdest !== '0) begin errors++; $display("FAIL reset_tlast_tdest: got %b/%0d want 0/0", axis_tlast, axis_tdest); end
      checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL reset_credit: got %b want 0", credit_out); end
      checks++; if (overflow_err !== 1'b0 || framing_err !== 1'b0) begin errors++; $display("FAIL reset_errs: got %b%b want 00", overflow_err, framing_err); end
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_single_beat();
      logic [TW-1:0] e = '0;
      int n0 = bq.size();
      int c0 = credits_ret;
      e[0*FW +: FW] = FW'(32'h11);
      e[1*FW +: FW] = FW'(32'h22);
      e[2*FW +: FW] = FW'(32'h33);
      e[3*FW +: FW] = FW'(32'h44);
      axis_tready = 1'b1;
      send_flit(32'h11, 5, 1'b0, 1'b1);
      send_flit(32'h22, 5, 1'b0, 1'b1);
      send_flit(32'h33, 5, 1'b0, 1'b1);
      send_flit(32'h44, 5, 1'b1, 1'b1);
      checks++; if (axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_latency_early: tvalid %b want 0", axis_tvalid); end
      tick();
      checks++; if (axis_tvalid !== 1'b1) begin errors++; $display("FAIL single_latency: tvalid %b want 1", axis_tvalid); end
      wait_beats(n0 + 1, 20);
      repeat (3) tick();
      checks++;
      if (bq.size() != n0 + 1) begin errors++; $display("FAIL single_count: got %0d beats want 1", bq.size() - n0); end
      else if (bq[n0] !== e || lq[n0] !== 1'b1 || dq[n0] !== DW'(5)) begin
         errors++; $display("FAIL single_beat: got %h last=%b dest=%0d want %h last=1 dest=5", bq[n0][4*FW-1:0], lq[n0], dq[n0], e[4*FW-1:0]);
      end
      checks++; if (credits_ret - c0 != 4) begin errors++; $display("FAIL single_credits: got %0d want 4", credits_ret - c0); end
   endtask

   task automatic test_backpressure();
      logic [TW-1:0] hold;
      int n0 = bq.size();
      int c0 = credits_ret;
      axis_tready = 1'b0;
      for (int i = 0; i < 11; i++) send_flit(32'h100 + i, 2, 1'b0, 1'b1);
      repeat (4) tick();
      hold = axis_tdata;
      checks++; if (axis_tvalid !== 1'b1 || hold !== mk_beat(32'h100, 4) || axis_tlast !== 1'b0) begin
         errors++; $display("FAIL bp_first_beat: v=%b got %h last=%b want %h last=0", axis_tvalid, hold[4*FW-1:0], axis_tlast, mk_beat(32'h100, 4));
      end
      repeat (5) tick();
      checks++; if (axis_tvalid !== 1'b1 || axis_tdata !== hold) begin errors++; $display("FAIL bp_stable: v=%b got %h want %h", axis_tvalid, axis_tdata[4*FW-1:0], hold[4*FW-1:0]); end
      checks++; if (credits_ret - c0 != 7) begin errors++; $display("FAIL bp_credits_held: got %0d want 7", credits_ret - c0); end
      checks++; if (sent - credits_ret != DEPTH) begin errors++; $display("FAIL bp_buffer_full: outstanding %0d want %0d", sent - credits_ret, DEPTH); end
      checks++; if (overflow_err !== 1'b0 || bq.size() != n0) begin errors++; $display("FAIL bp_no_overflow: ovf=%b beats=%0d want 0/0", overflow_err, bq.size() - n0); end
      axis_tready = 1'b1;
      send_flit(32'h10B, 2, 1'b1, 1'b1);
      wait_beats(n0 + 3, 40);
      repeat (4) tick();
      checks++;
      if (bq.size() != n0 + 3) begin errors++; $display("FAIL bp_beat_count: got %0d want 3", bq.size() - n0); end
      else begin
         for (int b = 0; b < 3; b++) begin
            checks++;
            if (bq[n0+b] !== mk_beat(32'h100 + 4*b, 4) || lq[n0+b] !== (b == 2) || dq[n0+b] !== DW'(2)) begin
               errors++; $display("FAIL bp_beat%0d: got %h last=%b dest=%0d want %h last=%b dest=2", b, bq[n0+b][4*FW-1:0], lq[n0+b], dq[n0+b], mk_beat(32'h100 + 4*b, 4), (b == 2));
            end
         end
      end
      checks++; if (credits_ret - c0 != 12) begin errors++; $display("FAIL bp_total_credits: got %0d want 12", credits_ret - c0); end
   endtask

   task automatic test_back_to_back();
      int n0 = bq.size();
      axis_tready = 1'b1;
      for (int i = 0; i < 24; i++) send_flit(32'h300 + i, (i < 12) ? 7 : 9, (i % 12) == 11, 1'b1);
      wait_beats(n0 + 6, 60);
      checks++;
      if (bq.size() != n0 + 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", bq.size() - n0); end
      else begin
         for (int j = 0; j < 6; j++) begin
            checks++;
            if (bq[n0+j] !== mk_beat(32'h300 + 4*j, 4) || lq[n0+j] !== (j == 2 || j == 5) || dq[n0+j] !== DW'((j < 3) ? 7 : 9)) begin
               errors++; $display("FAIL b2b_beat%0d: got %h last=%b dest=%0d want %h last=%b", j, bq[n0+j][4*FW-1:0], lq[n0+j], dq[n0+j], mk_beat(32'h300 + 4*j, 4), (j == 2 || j == 5));
            end
         end
         for (int j = 1; j < 6; j++) begin
            checks++;
            if (hq[n0+j] - hq[n0+j-1] != 4) begin errors++; $display("FAIL b2b_rate%0d: spacing %0d want 4", j, hq[n0+j] - hq[n0+j-1]); end
         end
      end
      checks++; if (timeouts != 0) begin errors++; $display("FAIL credit_stall: timeouts %0d want 0", timeouts); end
   endtask

   task automatic test_early_tail();
      int n0 = bq.size();
      checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL framing_clean: got %b want 0", framing_err); end
      axis_tready = 1'b1;
      send_flit(32'hA0, 3, 1'b0, 1'b1);
      send_flit(32'hA1, 3, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) send_flit(32'hB0 + k, 3, k == 3, 1'b1);
      wait_beats(n0 + 2, 30);
      checks++;
      if (bq.size() != n0 + 2) begin errors++; $display("FAIL early_count: got %0d want 2", bq.size() - n0); end
      else begin
         checks++;
         if (bq[n0] !== mk_beat(32'hA0, 2) || lq[n0] !== 1'b1 || dq[n0] !== DW'(3)) begin
            errors++; $display("FAIL early_beat: got %h last=%b want %h last=1", bq[n0][4*FW-1:0], lq[n0], mk_beat(32'hA0, 2));
         end
         checks++;
         if (bq[n0+1] !== mk_beat(32'hB0, 4) || lq[n0+1] !== 1'b1 || dq[n0+1] !== DW'(3)) begin
            errors++; $display("FAIL early_next: got %h last=%b want %h last=1", bq[n0+1][4*FW-1:0], lq[n0+1], mk_beat(32'hB0, 4));
         end
      end
      checks++; if (framing_err !== 1'b1) begin errors++; $display("FAIL early_framing: got %b want 1", framing_err); end
   endtask

   task automatic test_overflow();
      int n0 = bq.size();
      int c0 = credits_ret;
      int c1;
      axis_tready = 1'b0;
      for (int i = 0; i < 11; i++) send_flit(32'h500 + i, 1, 1'b0, 1'b1);
      repeat (3) tick();
      checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b want 0", overflow_err); end
      c1 = credits_ret;
      send_flit(32'h50B, 1, 1'b1, 1'b0);
      repeat (3) tick();
      checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow_err); end
      checks++; if (credits_ret != c1 || c1 - c0 != 7) begin errors++; $display("FAIL ovf_credits: got %0d/%0d want 7/7", c1 - c0, credits_ret - c0); end
      axis_tready = 1'b1;
      repeat (15) tick();
      checks++; if (bq.size() != n0 + 2) begin errors++; $display("FAIL ovf_beats: got %0d want 2", bq.size() - n0); end
      checks++; if (credits_ret - c0 != 11) begin errors++; $display("FAIL ovf_total_credits: got %0d want 11", credits_ret - c0); end
   endtask

   task automatic test_reset_mid();
      int n0;
      axis_tready = 1'b1;
      send_flit(32'h600, 4, 1'b0, 1'b1);
      send_flit(32'h601, 4, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      checks++; if (axis_tvalid !== 1'b0 || credit_out !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: v=%b c=%b want 0/0", axis_tvalid, credit_out); end
      checks++; if (overflow_err !== 1'b0 || framing_err !== 1'b0) begin errors++; $display("FAIL rst_mid_errs: got %b%b want 00", overflow_err, framing_err); end
      sent = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      n0 = bq.size();
      repeat (8) tick();
      checks++; if (bq.size() != n0 || axis_tvalid !== 1'b0 || credits_ret != 0) begin
         errors++; $display("FAIL rst_mid_stale: beats=%0d v=%b credits=%0d want 0/0/0", bq.size() - n0, axis_tvalid, credits_ret);
      end
      for (int k = 0; k < 4; k++) send_flit(32'h700 + k, 6, k == 3, 1'b1);
      wait_beats(n0 + 1, 20);
      repeat (3) tick();
      checks++;
      if (bq.size() != n0 + 1) begin errors++; $display("FAIL rst_after_count: got %0d want 1", bq.size() - n0); end
      else if (bq[n0] !== mk_beat(32'h700, 4) || dq[n0] !== DW'(6) || lq[n0] !== 1'b1) begin
         errors++; $display("FAIL rst_after_beat: got %h dest=%0d want %h dest=6", bq[n0][4*FW-1:0], dq[n0], mk_beat(32'h700, 4));
      end
      checks++; if (credits_ret != 4) begin errors++; $display("FAIL rst_after_credits: got %0d want 4", credits_ret); end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_backpressure();
      test_back_to_back();
      test_early_tail();
      test_overflow();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
